// File: rtl/matrix_scan_scheduler.sv
// 8x8 LED matrix row scanner: SCAN_DIV-cycle row slots with BLANK_CYC leading blank cycles, moving-block overlay, flashing.
// Define DOUBLE_BUFFER_EN to write into a shadow buffer that is copied to the active buffer at a frame boundary after commit.
module matrix_scan_scheduler #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       mv_en,
    input  logic [2:0] mv_row,
    input  logic [7:0] mv_cols,
    input  logic       flash_en,
    input  logic       flash_tick,
    input  logic       commit,
    output logic [7:0] cols,
    output logic [7:0] rows_n,
    output logic       frame_start
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_row;
    logic [7:0]  r_active [8];
    logic        r_flash;
    logic        r_new_frame;
    logic [7:0]  r_cols;
    logic [7:0]  r_rows_n;
    logic        r_frame_start;
    logic        w_slot_end;
    logic        w_wrap;
    logic [7:0]  w_row_bits;
    logic [7:0]  w_cols_nxt;
    logic [7:0]  w_rows_n_nxt;

    assign w_slot_end = (r_cnt == 16'(SCAN_DIV - 1));
    assign w_wrap     = w_slot_end && (r_row == 3'd7);

    always_comb begin
        w_cnt_nxt    = w_slot_end ? 16'd0 : r_cnt + 16'd1;
        w_state_nxt  = (w_cnt_nxt < 16'(BLANK_CYC)) ? ST_BLANK : ST_DRIVE;
        w_cols_nxt   = 8'h00;
        w_rows_n_nxt = 8'hFF;
        if (r_state == ST_DRIVE && !r_flash) begin
            w_cols_nxt   = w_row_bits | ((mv_en && mv_row == r_row) ? mv_cols : 8'h00);
            w_rows_n_nxt = ~(8'd1 << r_row);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= 16'd0;
            r_row         <= 3'd0;
            r_state       <= ST_BLANK;
            r_new_frame   <= 1'b0;
            r_cols        <= 8'h00;
            r_rows_n      <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            if (w_slot_end) begin
                r_row <= r_row + 3'd1;
            end
            r_state       <= w_state_nxt;
            // r_new_frame marks row 0 / cnt 0 reached by a wrap, so a reset restart never pulses
            r_new_frame   <= w_wrap;
            r_cols        <= w_cols_nxt;
            r_rows_n      <= w_rows_n_nxt;
            r_frame_start <= r_new_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !flash_en) begin
            r_flash <= 1'b0;
        end else if (flash_tick) begin
            r_flash <= ~r_flash;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    logic [7:0] r_shadow [8];
    logic       r_commit_pending;

    assign w_row_bits = r_active[r_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_active[i] <= 8'h00;
                r_shadow[i] <= 8'h00;
            end
            r_commit_pending <= 1'b0;
        end else begin
            if (wr_en) begin
                r_shadow[wr_row] <= wr_data;
            end
            // Copy uses pre-write shadow; a commit arriving on the wrap itself is taken now
            if (w_wrap && (r_commit_pending || commit)) begin
                for (int i = 0; i < 8; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_commit_pending <= 1'b0;
            end else if (commit) begin
                r_commit_pending <= 1'b1;
            end
        end
    end
`else
    logic w_unused_commit;

    assign w_unused_commit = commit;
    // Forward a write to the row being driven so it shows on the very next output
    assign w_row_bits = (wr_en && wr_row == r_row) ? wr_data : r_active[r_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_active[i] <= 8'h00;
            end
        end else if (wr_en) begin
            r_active[wr_row] <= wr_data;
        end
    end
`endif

    assign cols        = r_cols;
    assign rows_n      = r_rows_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Directed bench for matrix_scan_scheduler with SCAN_DIV=8, BLANK_CYC=2 (64-cycle frames).
// t_now is the scan cycle index whose registered outputs are currently visible.
module tb_matrix_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       mv_en = 1'b0;
    logic [2:0] mv_row = 3'd0;
    logic [7:0] mv_cols = 8'h00;
    logic       flash_en = 1'b0;
    logic       flash_tick = 1'b0;
    logic       commit = 1'b0;
    logic [7:0] cols;
    logic [7:0] rows_n;
    logic       frame_start;

    int checks = 0;
    int failures = 0;
    int t_now = -1;
    int fs_count = 0;

    matrix_scan_scheduler #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .mv_en       (mv_en),
        .mv_row      (mv_row),
        .mv_cols     (mv_cols),
        .flash_en    (flash_en),
        .flash_tick  (flash_tick),
        .commit      (commit),
        .cols        (cols),
        .rows_n      (rows_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, t_now, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t_now++;
    endtask

    task automatic goto(input int t);
        if (t < t_now) begin
            check_val("goto_order", t_now, t);
        end
        while (t_now < t) begin
            step();
        end
    endtask

    task automatic wr(input logic [2:0] row, input logic [7:0] data, input logic do_commit);
        wr_en   = 1'b1;
        wr_row  = row;
        wr_data = data;
        commit  = do_commit;
        step();
        wr_en   = 1'b0;
        commit  = 1'b0;
    endtask

    task automatic pulse_tick();
        flash_tick = 1'b1;
        step();
        flash_tick = 1'b0;
    endtask

    initial begin
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_val("rst_cols", cols, 8'h00);
        check_val("rst_rows_n", rows_n, 8'hFF);
        check_val("rst_fs", frame_start, 1'b0);
        reset = 1'b0;
        t_now = -1;

        // Load image; the commit makes it visible from frame 1 under double buffering too
        wr(3'd3, 8'hA5, 1'b0);
        check_val("fs_t0", frame_start, 1'b0);
        wr(3'd2, 8'h0F, 1'b1);

        goto(88);
        check_val("r3_blank_cols", cols, 8'h00);
        check_val("r3_blank_rows", rows_n, 8'hFF);
        goto(89);
        check_val("r3_blank2_cols", cols, 8'h00);
        goto(90);
        check_val("r3_drive_cols", cols, 8'hA5);
        check_val("r3_drive_rows", rows_n, 8'hF7);
        goto(95);
        check_val("r3_end_cols", cols, 8'hA5);
        goto(96);
        check_val("r4_blank_cols", cols, 8'h00);
        goto(98);
        check_val("r4_drive_cols", cols, 8'h00);
        check_val("r4_drive_rows", rows_n, 8'hEF);

        mv_en   = 1'b1;
        mv_row  = 3'd2;
        mv_cols = 8'h80;
        goto(146);
        check_val("ovl_r2_cols", cols, 8'h8F);
        check_val("ovl_r2_rows", rows_n, 8'hFB);
        mv_row = 3'd5;
        step();
        check_val("ovl_off_r2_cols", cols, 8'h0F);
        goto(170);
        check_val("ovl_r5_cols", cols, 8'h80);
        check_val("ovl_r5_rows", rows_n, 8'hDF);
        mv_en = 1'b0;

        goto(191);
        for (int i = 0; i < 192; i++) begin
            step();
            if (frame_start) fs_count++;
            if (t_now % 64 == 0) begin
                check_val("fs_at_frame", frame_start, 1'b1);
            end
        end
        check_val("fs_count_3frames", fs_count, 3);

        flash_en = 1'b1;
        pulse_tick();
        goto(410);
        check_val("flash_dark_cols", cols, 8'h00);
        check_val("flash_dark_rows", rows_n, 8'hFF);
        goto(447);
        pulse_tick();
        goto(474);
        check_val("flash_lit_cols", cols, 8'hA5);
        check_val("flash_lit_rows", rows_n, 8'hF7);
        goto(511);
        pulse_tick();
        check_val("flash_fs_kept", frame_start, 1'b1);
        goto(538);
        check_val("flash_dark2_cols", cols, 8'h00);
        flash_en = 1'b0;
        goto(546);
        check_val("flash_off_rows", rows_n, 8'hEF);
        goto(602);
        check_val("flash_off_cols", cols, 8'hA5);

`ifdef DOUBLE_BUFFER_EN
        wr(3'd0, 8'hFF, 1'b0);
        wr(3'd5, 8'h3C, 1'b1);
        goto(618);
        check_val("db_r5_pending", cols, 8'h00);
        goto(642);
        check_val("db_r0_next_frame", cols, 8'hFF);
        check_val("db_r0_rows", rows_n, 8'hFE);
        goto(666);
        check_val("db_r3_kept", cols, 8'hA5);
        goto(682);
        check_val("db_r5_next_frame", cols, 8'h3C);
`else
        wr(3'd3, 8'hC3, 1'b0);
        step();
        check_val("direct_r3_update", cols, 8'hC3);
        wr(3'd5, 8'h3C, 1'b1);
        goto(618);
        check_val("direct_r5", cols, 8'h3C);
        goto(642);
        check_val("direct_r0_zero", cols, 8'h00);
        check_val("direct_r0_rows", rows_n, 8'hFE);
        goto(666);
        check_val("direct_r3_new", cols, 8'hC3);
`endif

        goto(746);
        check_val("pre_rst_r5_cols", cols, 8'h3C);
        reset = 1'b1;
        step();
        check_val("midrst_cols", cols, 8'h00);
        check_val("midrst_rows", rows_n, 8'hFF);
        check_val("midrst_fs", frame_start, 1'b0);
        reset = 1'b0;
        t_now = -1;
        step();
        check_val("restart_no_fs", frame_start, 1'b0);
        goto(2);
        check_val("restart_r0_rows", rows_n, 8'hFE);
        check_val("restart_r0_cols", cols, 8'h00);
        goto(18);
        check_val("restart_r2_cleared", cols, 8'h00);
        goto(26);
        check_val("restart_r3_cleared", cols, 8'h00);
        check_val("restart_r3_rows", rows_n, 8'hF7);
        goto(64);
        check_val("restart_fs_frame1", frame_start, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_scan_scheduler.md
MATRIX_SCAN_SCHEDULER -- requirements
Module: matrix_scan_scheduler

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per row slot; legal range 2..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 16: blanking cycles at the start of each row slot; legal range 1..SCAN_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  frame-buffer write strobe, one row per cycle.
REQ-006 SHALL have port wr_row  input  3  row index for the write.
REQ-007 SHALL have port wr_data  input  8  column bits for the row; 1 = LED on.
REQ-008 SHALL have port mv_en  input  1  enables the moving-block overlay.
REQ-009 SHALL have port mv_row  input  3  row carrying the moving block.
REQ-010 SHALL have port mv_cols  input  8  moving-block column bits.
REQ-011 SHALL have port flash_en  input  1  enables whole-matrix flashing (win/lose display).
REQ-012 SHALL have port flash_tick  input  1  single-cycle pulse that toggles the flash phase.
REQ-013 SHALL have port commit  input  1  shadow-to-active request; used only under REQ-031.
REQ-014 SHALL have port cols  output  8  column drive, active-high.
REQ-015 SHALL have port rows_n  output  8  row drive, active-low, one-hot-low.
REQ-016 SHALL have port frame_start  output  1  one-cycle pulse at the start of each frame.

Function
REQ-017 SHALL hold an 8 x 8-bit active frame buffer and a 16-bit slot counter cnt.
REQ-018 SHALL hold a 3-bit row index row.
REQ-019 SHALL increment cnt every cycle; at cnt = SCAN_DIV-1, cnt SHALL wrap to 0 and row SHALL advance, with 7 wrapping to 0.
REQ-020 SHALL implement FSM states BLANK and DRIVE.
REQ-021 SHALL be in BLANK while cnt < BLANK_CYC and in DRIVE otherwise.
REQ-022 In BLANK, cols SHALL be 8'h00 and rows_n SHALL be 8'hFF.
REQ-023 In DRIVE, rows_n SHALL be ~(1<<row).
REQ-024 In DRIVE, cols SHALL be buf[row] OR (mv_en && mv_row==row ? mv_cols : 8'h00).
REQ-025 cols, rows_n and frame_start SHALL be registered and SHALL lag the cnt/row/state that produces them by exactly one cycle.
REQ-026 frame_start SHALL be 1 for exactly one cycle, in the output cycle corresponding to row 7 -> 0, cnt = 0.
REQ-027 A write SHALL update the target entry at the clk edge on which wr_en is sampled.
REQ-028 A write to the row currently in DRIVE SHALL appear on cols in the cycle after it is sampled.
REQ-029 flash_phase SHALL toggle on each flash_tick while flash_en = 1, and SHALL be forced to 0 while flash_en = 0.
REQ-030 While flash_phase = 1, cols SHALL be 8'h00 and rows_n SHALL be 8'hFF; scanning continues and frame_start is unaffected.

Configuration
REQ-031 When DOUBLE_BUFFER_EN is defined:
- writes go to an 8 x 8 shadow buffer;
- commit sets commit_pending;
- at the cycle where row wraps 7 -> 0 with commit_pending = 1, active <= shadow using pre-write shadow contents, and commit_pending clears;
- a write in that same cycle lands in shadow only;
- commit coincident with the wrap is honoured at that wrap.
REQ-032 When DOUBLE_BUFFER_EN is undefined, writes go directly to the active buffer, commit is ignored, and no shadow storage is built.

Reset
REQ-033 While reset = 1, all of the following SHALL be cleared at the next edge:
- cnt = 0, row = 0, state = BLANK;
- both buffers all-zero;
- flash_phase = 0, commit_pending = 0;
- cols = 8'h00, rows_n = 8'hFF, frame_start = 0.
REQ-034 Reset SHALL take priority over wr_en, commit and flash_tick in the same cycle.
REQ-035 Reset asserted mid-slot or mid-frame SHALL restart scanning at row 0, cnt 0, with no frame_start pulse for the restart.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-036 Scan sequence: reset, then write row3 = 8'hA5 -> during row-3 DRIVE, cols = 8'hA5 and rows_n = 8'hF7, and cols = 8'h00 for the 2 blank cycles of each slot.
REQ-037 Overlay: buf[2] = 8'h0F, mv_en=1, mv_row=2, mv_cols=8'h80 -> row-2 cols = 8'h8F; with mv_row=5, row-2 cols = 8'h0F.
REQ-038 Frame timing: free-run 3 frames -> frame_start high exactly once per 64 cycles, aligned to row 0 entry.
REQ-039 Flash: flash_en=1, flash_tick every 64 cycles -> alternate frames fully dark (cols=0, rows_n=FF); flash_en=0 -> image restored next slot.
REQ-040 Reset mid-slot: assert reset during row 5 DRIVE -> next cycle cols=0, rows_n=FF, then row 0 timing restarts and prior contents read 8'h00.
REQ-041 DOUBLE_BUFFER_EN: write row0 = 8'hFF and pulse commit in row 4 -> row 0 stays 8'h00 in the current frame and shows 8'hFF from the next frame.
